// File: rtl/block_acc_pkg.sv
// Shared defaults and output-register state type for the block accumulator.
package block_acc_pkg;

    localparam int unsigned DefDataW   = 32;
    localparam int unsigned DefAccW    = 34;
    localparam int unsigned DefBlockLen = 4;

    typedef enum logic {
        StEmpty,
        StFull
    } out_st_e;

endpackage

// File: rtl/block_accumulator_if.sv
// Sample-in / block-out handshake bundle for block_accumulator.
interface block_accumulator_if
    import block_acc_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ACC_W  = DefAccW
);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_y;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_sum;
    logic signed [DATA_W-1:0] out_max;
    logic                     out_ovf;

    modport master (
        output in_valid, in_y, out_ready,
        input  in_ready, out_valid, out_sum, out_max, out_ovf
    );

    modport slave (
        input  in_valid, in_y, out_ready,
        output in_ready, out_valid, out_sum, out_max, out_ovf
    );

endinterface

// File: rtl/sat_add.sv
// Signed saturating add of a wide accumulator and a narrower sign-extended sample.
module sat_add #(
    parameter int unsigned ACC_W  = 34,
    parameter int unsigned DATA_W = 32
) (
    input  logic signed [ACC_W-1:0]  a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  sum_o,
    output logic                     clamp_o
);

    logic [ACC_W:0] wide;

    // One guard bit is enough because the sample is narrower than the accumulator.
    always_comb begin
        wide    = {a_i[ACC_W-1], a_i} + {{(ACC_W + 1 - DATA_W){b_i[DATA_W-1]}}, b_i};
        clamp_o = wide[ACC_W] ^ wide[ACC_W-1];
        if (!clamp_o) begin
            sum_o = wide[ACC_W-1:0];
        end else if (wide[ACC_W]) begin
            sum_o = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            sum_o = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/block_accumulator.sv
// Accumulates BLOCK_LEN signed samples into a saturated sum, max and overflow flag,
// presented through a one-entry output register.
module block_accumulator
    import block_acc_pkg::*;
#(
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned ACC_W     = DefAccW,
    parameter int unsigned BLOCK_LEN = DefBlockLen
) (
    input logic clk,
    input logic rst,
    block_accumulator_if.slave bus_io
);

    localparam int unsigned     CntW    = $clog2(BLOCK_LEN);
    localparam logic [CntW-1:0] LastCnt = CntW'(BLOCK_LEN - 1);

    logic [CntW-1:0]          cnt_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [DATA_W-1:0] max_q;
    logic                     ovf_q;
    out_st_e                  st_q;
    logic signed [ACC_W-1:0]  sum_q;
    logic signed [DATA_W-1:0] omax_q;
    logic                     oovf_q;

    logic                     first, last, accept, full;
    logic signed [ACC_W-1:0]  add_a, sum;
    logic                     clamp;
    logic signed [DATA_W-1:0] max_upd;
    logic                     ovf_upd;

    assign first = (cnt_q == '0);
    assign last  = (cnt_q == LastCnt);
    assign full  = (st_q == StFull);

    // Only the completing sample stalls, and only while the held block is not draining.
    assign bus_io.in_ready = !(last && full && !bus_io.out_ready);
    assign accept          = bus_io.in_valid && bus_io.in_ready;

    // A zero addend on the first sample makes the sum a plain sign-extended load.
    assign add_a = first ? '0 : acc_q;

    sat_add #(
        .ACC_W (ACC_W),
        .DATA_W(DATA_W)
    ) u_sat_add (
        .a_i    (add_a),
        .b_i    (bus_io.in_y),
        .sum_o  (sum),
        .clamp_o(clamp)
    );

    assign max_upd = (first || (bus_io.in_y > max_q)) ? bus_io.in_y : max_q;
    assign ovf_upd = ovf_q | clamp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            max_q  <= '0;
            ovf_q  <= 1'b0;
            st_q   <= StEmpty;
            sum_q  <= '0;
            omax_q <= '0;
            oovf_q <= 1'b0;
        end else begin
            if (accept) begin
                acc_q <= sum;
                max_q <= max_upd;
                if (last) begin
                    cnt_q <= '0;
                    ovf_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + CntW'(1);
                    ovf_q <= ovf_upd;
                end
            end
            unique case (st_q)
                StEmpty: begin
                    if (accept && last) begin
                        st_q   <= StFull;
                        sum_q  <= sum;
                        omax_q <= max_upd;
                        oovf_q <= ovf_upd;
                    end
                end
                StFull: begin
                    if (accept && last) begin
                        sum_q  <= sum;
                        omax_q <= max_upd;
                        oovf_q <= ovf_upd;
                    end else if (bus_io.out_ready) begin
                        st_q <= StEmpty;
                    end
                end
            endcase
        end
    end

    assign bus_io.out_valid = full;
    assign bus_io.out_sum   = sum_q;
    assign bus_io.out_max   = omax_q;
    assign bus_io.out_ovf   = oovf_q;

endmodule

// File: tb/tb_block_accumulator.sv
// Directed and random checks of block_accumulator (block lengths 4 and 8) against a
// sample-list reference model.
module tb_block_accumulator;
    import block_acc_pkg::*;

    localparam longint SatMax = 64'sd8589934591;
    localparam longint SatMin = -64'sd8589934592;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    block_accumulator_if #(.DATA_W(32), .ACC_W(34)) if4 ();
    block_accumulator_if #(.DATA_W(32), .ACC_W(34)) if8 ();

    block_accumulator #(.DATA_W(32), .ACC_W(34), .BLOCK_LEN(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .bus_io(if4)
    );

    block_accumulator #(.DATA_W(32), .ACC_W(34), .BLOCK_LEN(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .bus_io(if8)
    );

    // Reference model: index 0 is the 4-sample instance, index 1 the 8-sample one.
    int          blen[2] = '{4, 8};
    int          blk[2][8];
    int          nblk[2];
    bit          m_valid[2];
    longint      m_sum[2];
    int          m_max[2];
    bit          m_ovf[2];

    bit          v_d[2];
    logic [31:0] y_d[2];
    bit          r_d;
    bit          acc_last[2];

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int sel, input bit v, input logic [31:0] y, input bit rdy);
        v_d[0] = 1'b0;
        v_d[1] = 1'b0;
        y_d[0] = $urandom;
        y_d[1] = $urandom;
        v_d[sel] = v;
        y_d[sel] = y;
        r_d = rdy;
        if4.in_valid  = v_d[0];
        if4.in_y      = y_d[0];
        if4.out_ready = r_d;
        if8.in_valid  = v_d[1];
        if8.in_y      = y_d[1];
        if8.out_ready = r_d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            nblk[i]    = 0;
            m_valid[i] = 1'b0;
            m_sum[i]   = 0;
            m_max[i]   = 0;
            m_ovf[i]   = 1'b0;
        end
    endtask

    // Sum is clamped after every addition, so intermediate values matter.
    task automatic finish_block(input int i);
        longint s;
        int     mx;
        bit     o;
        s  = longint'(blk[i][0]);
        mx = blk[i][0];
        o  = 1'b0;
        for (int k = 1; k < blen[i]; k++) begin
            s = s + longint'(blk[i][k]);
            if (s > SatMax) begin
                s = SatMax;
                o = 1'b1;
            end else if (s < SatMin) begin
                s = SatMin;
                o = 1'b1;
            end
            if (blk[i][k] > mx) mx = blk[i][k];
        end
        m_sum[i]   = s;
        m_max[i]   = mx;
        m_ovf[i]   = o;
        m_valid[i] = 1'b1;
    endtask

    task automatic check_out(input int i);
        chk($sformatf("out_valid%0d", blen[i]), (i == 0) ? if4.out_valid : if8.out_valid,
            m_valid[i]);
        if (m_valid[i]) begin
            chk($sformatf("out_sum%0d", blen[i]), (i == 0) ? if4.out_sum : if8.out_sum, m_sum[i]);
            chk($sformatf("out_max%0d", blen[i]), (i == 0) ? if4.out_max : if8.out_max, m_max[i]);
            chk($sformatf("out_ovf%0d", blen[i]), (i == 0) ? if4.out_ovf : if8.out_ovf, m_ovf[i]);
        end
    endtask

    // One clock: check in_ready at the falling edge, step the model, check outputs after.
    task automatic cycle();
        bit ir;
        bit hs[2];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            ir = !((nblk[i] == blen[i] - 1) && m_valid[i] && !r_d);
            chk($sformatf("in_ready%0d", blen[i]), (i == 0) ? if4.in_ready : if8.in_ready, ir);
            acc_last[i] = v_d[i] && ir;
            hs[i]       = m_valid[i] && r_d;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (acc_last[i]) begin
                blk[i][nblk[i]] = int'(y_d[i]);
                nblk[i]++;
                if (nblk[i] == blen[i]) begin
                    nblk[i] = 0;
                    finish_block(i);
                end else if (hs[i]) begin
                    m_valid[i] = 1'b0;
                end
            end else if (hs[i]) begin
                m_valid[i] = 1'b0;
            end
            check_out(i);
        end
    endtask

    // rdy_mode: 0/1 hold out_ready at that value, 2 randomises it every cycle.
    task automatic send(input int sel, input logic [31:0] y, input int rdy_mode,
                        input int gap_max);
        int gaps;
        gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        for (int g = 0; g < gaps; g++) begin
            set_in(sel, 1'b0, $urandom, (rdy_mode == 2) ? 1'($urandom) : rdy_mode[0]);
            cycle();
        end
        for (int t = 0; t < 40; t++) begin
            set_in(sel, 1'b1, y, (rdy_mode == 2) ? 1'($urandom) : rdy_mode[0]);
            cycle();
            if (acc_last[sel]) return;
        end
        vectors++;
        errors++;
        $error("FAIL send_timeout: observed no accept expected accept within 40 cycles");
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_in(0, 1'($urandom), $urandom, 1'($urandom));
        #1;
        model_clear();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 2; i++) check_out(i);
            chk("rst_sum4", if4.out_sum, 0);
            chk("rst_max4", if4.out_max, 0);
            chk("rst_ovf4", if4.out_ovf, 0);
            chk("rst_in_ready4", if4.in_ready, 1);
            chk("rst_in_ready8", if8.in_ready, 1);
            repeat (2) @(posedge clk);
            set_in(1, 1'($urandom), $urandom, 1'($urandom));
            #1;
        end
        @(negedge clk);
        rst = 1'b1;
        set_in(0, 1'b0, 32'd0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_y();
        case ($urandom_range(3, 0))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        model_clear();
        set_in(0, 1'b0, 32'd0, 1'b1);
        do_reset();

        // Basic block
        send(0, 32'd1, 1, 0);
        send(0, -32'sd2, 1, 0);
        send(0, 32'd3, 1, 0);
        send(0, 32'd10, 1, 0);
        chk("basic_valid", if4.out_valid, 1);
        chk("basic_sum", if4.out_sum, 12);
        chk("basic_max", if4.out_max, 10);
        chk("basic_ovf", if4.out_ovf, 0);
        set_in(0, 1'b0, 32'd0, 1'b1);
        cycle();

        // Back-pressure: second block completes into a held register
        for (int k = 0; k < 7; k++) send(0, 32'd5, 0, 0);
        chk("bp_held_sum", if4.out_sum, 20);
        set_in(0, 1'b1, 32'd5, 1'b0);
        cycle();
        chk("bp_stall", if4.in_ready, 0);
        send(0, 32'd5, 1, 0);
        chk("bp_reload_valid", if4.out_valid, 1);
        chk("bp_reload_sum", if4.out_sum, 20);
        set_in(0, 1'b0, 32'd0, 1'b1);
        cycle();

        // Positive saturation on the 8-sample instance, then a clean block
        for (int k = 0; k < 8; k++) send(1, 32'h7FFF_FFFF, 1, 0);
        chk("pos_sum", if8.out_sum, SatMax);
        chk("pos_ovf", if8.out_ovf, 1);
        for (int k = 0; k < 8; k++) send(1, 32'd0, 1, 0);
        chk("zero_sum", if8.out_sum, 0);
        chk("zero_ovf", if8.out_ovf, 0);

        // Negative limit reached exactly without clamping
        for (int k = 0; k < 4; k++) send(0, 32'h8000_0000, 1, 0);
        chk("neg_sum", if4.out_sum, SatMin);
        chk("neg_ovf", if4.out_ovf, 0);
        chk("neg_max", if4.out_max, -64'sd2147483648);

        // Reset mid-block discards the partial block
        send(0, 32'd7, 1, 0);
        send(0, 32'd9, 1, 0);
        do_reset();
        for (int k = 0; k < 4; k++) send(0, 32'd1, 1, 0);
        chk("mid_rst_sum", if4.out_sum, 4);
        chk("mid_rst_max", if4.out_max, 1);

        // Gapped input with junk on in_y while in_valid is low
        send(0, 32'd4, 1, 3);
        send(0, -32'sd4, 1, 3);
        send(0, 32'd6, 1, 3);
        send(0, 32'd0, 1, 3);
        chk("gap_sum", if4.out_sum, 6);
        chk("gap_max", if4.out_max, 6);

        // Random traffic with random back-pressure on both instances
        for (int n = 0; n < 400; n++) send(int'($urandom_range(1, 0)), rand_y(), 2, 2);
        for (int n = 0; n < 4; n++) begin
            set_in(0, 1'b0, 32'd0, 1'b1);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
